// File: rtl/r_alu_arbiter_if.sv
// Bundle of request, response and ALU-side signals shared between the
// two requesters, the arbiter and the external combinational R-type ALU.
interface r_alu_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_instr;
  logic [31:0] req0_in1;
  logic [31:0] req0_in2;
  logic [31:0] req1_instr;
  logic [31:0] req1_in1;
  logic [31:0] req1_in2;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] alu_instr;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [31:0] alu_out;
  logic        busy;

  // Arbiter view: consumes requests and ALU result, produces everything else
  modport slave (
    input  req_valid, req0_instr, req0_in1, req0_in2,
           req1_instr, req1_in1, req1_in2, rsp_ready, alu_out,
    output req_ready, rsp_valid, rsp_data, rsp_err,
           alu_instr, alu_in1, alu_in2, busy
  );

  // Environment view: requesters plus the ALU
  modport master (
    output req_valid, req0_instr, req0_in1, req0_in2,
           req1_instr, req1_in1, req1_in2, rsp_ready, alu_out,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
           alu_instr, alu_in1, alu_in2, busy
  );
endinterface

// File: rtl/r_alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational
// R-type ALU. Each operation walks IDLE -> EXEC -> RESP -> IDLE; encodings
// outside the supported RV32I R-type subset are answered with an error flag.
module r_alu_arbiter #(
  parameter logic [31:0] ILLEGAL_RESULT = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  r_alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_last_grant;
  logic        r_grantee;
  logic [31:0] r_instr;
  logic [31:0] r_in1;
  logic [31:0] r_in2;
  logic [31:0] r_result;
  logic        r_err;

  logic        w_grant_idx;
  logic        w_accept;
  logic        w_legal;
  logic        w_rsp_done;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;

  assign w_opcode   = r_instr[6:0];
  assign w_funct3   = r_instr[14:12];
  assign w_funct7   = r_instr[31:25];
  assign w_legal    = (w_opcode == 7'b0110011) &&
                      ((w_funct7 == 7'h00) ||
                       ((w_funct7 == 7'h20) &&
                        ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
  assign w_accept   = (r_state == ST_IDLE) && (|bus.req_valid);
  assign w_rsp_done = (r_state == ST_RESP) && bus.rsp_ready[r_grantee];

  // Round-robin pick: a lone requester wins, on contention the one not served last
  always_comb begin
    w_grant_idx = 1'b0;
    case (bus.req_valid)
      2'b01:   w_grant_idx = 1'b0;
      2'b10:   w_grant_idx = 1'b1;
      2'b11:   w_grant_idx = ~r_last_grant;
      default: w_grant_idx = 1'b0;
    endcase
  end

  // Next-state and output decode; everything idles at zero unless the state says otherwise
  always_comb begin
    w_next_state  = r_state;
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;
    bus.alu_instr = 32'h0;
    bus.alu_in1   = 32'h0;
    bus.alu_in2   = 32'h0;
    bus.busy      = 1'b1;
    bus.rsp_data  = r_result;
    bus.rsp_err   = r_err;
    case (r_state)
      ST_IDLE: begin
        bus.busy = 1'b0;
        if (w_accept) begin
          bus.req_ready = w_grant_idx ? 2'b10 : 2'b01;
          w_next_state  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        bus.alu_instr = r_instr;
        bus.alu_in1   = r_in1;
        bus.alu_in2   = r_in2;
        w_next_state  = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid = r_grantee ? 2'b10 : 2'b01;
        if (w_rsp_done) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register plus operand capture on grant and result capture at the end of EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_grantee    <= 1'b0;
      r_instr      <= 32'h0;
      r_in1        <= 32'h0;
      r_in2        <= 32'h0;
      r_result     <= 32'h0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_grantee    <= w_grant_idx;
        r_last_grant <= w_grant_idx;
        r_instr      <= w_grant_idx ? bus.req1_instr : bus.req0_instr;
        r_in1        <= w_grant_idx ? bus.req1_in1   : bus.req0_in1;
        r_in2        <= w_grant_idx ? bus.req1_in2   : bus.req0_in2;
      end
      if (r_state == ST_EXEC) begin
        r_result <= w_legal ? bus.alu_out : ILLEGAL_RESULT;
        r_err    <= ~w_legal;
      end
    end
  end

endmodule

// File: doc/r_alu_arbiter.md
R_ALU_ARBITER -- requirements
Module: r_alu_arbiter

Interface
REQ-001 SHALL have parameter: ILLEGAL_RESULT, 32'h0000_0000, value returned on rsp_data for a rejected encoding.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: req_valid / req_ready  in / out  2 each  per-requester request handshake; bit i = requester i.
REQ-005 SHALL have ports: req0_instr, req0_in1, req0_in2  in  32 each  requester 0 instruction word and operands.
REQ-006 SHALL have ports: req1_instr, req1_in1, req1_in2  in  32 each  requester 1 instruction word and operands.
REQ-007 SHALL have ports: rsp_valid / rsp_ready  out / in  2 each  per-requester response handshake.
REQ-008 SHALL have ports: rsp_data  out  32  result; rsp_err  out  1  illegal-encoding flag; both shared and qualified by rsp_valid.
REQ-009 SHALL have ports: alu_instr, alu_in1, alu_in2  out  32 each  operands to the shared combinational R-type ALU.
REQ-010 SHALL have ports: alu_out  in  32  ALU result, same-cycle combinational; busy  out  1  FSM not in IDLE.

Function
REQ-011 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; EXEC always lasts exactly one cycle.
REQ-012 In IDLE, req_ready SHALL be asserted combinationally to exactly one requester with req_valid=1 (the grantee), else 2'b00; in EXEC/RESP req_ready=2'b00.
REQ-013 Grant SHALL be round-robin: when both valid, the requester not granted last wins; last_grant resets to 1, so requester 0 wins the first contention.
REQ-014 On req_valid[i]&req_ready[i], SHALL register instr/in1/in2 of requester i, record the grantee, update last_grant, and enter EXEC.
REQ-015 In EXEC, alu_instr/alu_in1/alu_in2 SHALL drive the registered values; alu_out SHALL be captured at the end of EXEC; in all other states they drive 0.
REQ-016 In EXEC, the registered instr SHALL be classified legal iff opcode[6:0]=7'b0110011 and funct7 is 7'h00, or funct7=7'h20 with funct3 in {000,101}.
REQ-017 Legal: rsp_data=captured alu_out, rsp_err=0; illegal: rsp_data=ILLEGAL_RESULT, rsp_err=1. The ALU is still driven for one cycle in both cases.
REQ-018 In RESP, rsp_valid SHALL be one-hot to the grantee; rsp_data/rsp_err SHALL be held stable until rsp_ready of that requester is sampled high.
REQ-019 Latency SHALL be fixed: request accepted at edge N -> rsp_valid high from cycle N+2; rsp_ready of the non-grantee SHALL be ignored.
REQ-020 On rsp handshake, SHALL return to IDLE; a new grant is possible in that IDLE cycle, so throughput is at best one operation per 3 cycles.
REQ-021 req_valid dropping or req operands changing after acceptance SHALL NOT affect the in-flight operation.
REQ-022 rsp_valid SHALL never be asserted to both requesters, and never while busy=0.

Reset
REQ-023 While rst=1 at an edge: state=IDLE, last_grant=1, registered instr/operands/result=0, rsp_err=0.
REQ-024 Outputs after reset: req_ready combinational per REQ-012, rsp_valid=2'b00, rsp_data=0, rsp_err=0, alu_*=0, busy=0.
REQ-025 Reset asserted in EXEC or RESP SHALL abort the operation with no response delivered; rsp_valid=0 from the next cycle.

Verification
REQ-026 req0 only: instr=0x003100B3 (add), in1=5, in2=7 -> req_ready[0]=1, rsp_valid=2'b01 two cycles later, rsp_data=12, rsp_err=0.
REQ-027 Both valid after reset: req0 add 1+1, req1 sub (0x403100B3) 3-5 -> req0 served first (rsp_data=2), then req1 (rsp_data=0xFFFFFFFE); with both held valid, grants alternate 0,1,0,1.
REQ-028 req1 instr=0x023100B3 (funct7=0x01, MUL) -> rsp_valid=2'b10, rsp_err=1, rsp_data=ILLEGAL_RESULT; next legal op returns rsp_err=0.
REQ-029 rsp_ready held low 3 cycles in RESP -> rsp_valid, rsp_data and rsp_err stable, req_ready=2'b00; completion on the 4th cycle, then IDLE.
REQ-030 rst pulsed during RESP -> rsp_valid=2'b00 next cycle, busy=0, and the next contention is won by requester 0.
